// File: rtl/fuzz_sig_collector_if.sv
// Sample/result bundle between the fuzzed design, the signature collector and its consumer.
// The slave side is the collector; the master side drives samples and accepts results.
interface fuzz_sig_collector_if #(
  parameter int Y_W   = 350,
  parameter int SIG_W = 32
);
  logic             start;
  logic [15:0]      num_samples;
  logic [Y_W-1:0]   y;
  logic             y_valid;
  logic [SIG_W-1:0] expected_sig;
  logic             busy;
  logic [SIG_W-1:0] sig;
  logic [15:0]      sample_cnt;
  logic             out_valid;
  logic             out_ready;
  logic             match;
  logic             timeout;

  modport slave (
    input  start, num_samples, y, y_valid, expected_sig, out_ready,
    output busy, sig, sample_cnt, out_valid, match, timeout
  );

  modport master (
    output start, num_samples, y, y_valid, expected_sig, out_ready,
    input  busy, sig, sample_cnt, out_valid, match, timeout
  );
endinterface

// File: rtl/fuzz_sig_collector.sv
// Folds each valid y sample into a MISR signature; after num_samples (or an idle timeout)
// holds the signature plus golden-compare on a valid/ready result until accepted.
module fuzz_sig_collector #(
  parameter int               Y_W     = 350,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED    = 32'h0,
  parameter int               TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  fuzz_sig_collector_if.slave     bus
);
  localparam int NCH    = (Y_W + SIG_W - 1) / SIG_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  state_t            state_q;
  logic [SIG_W-1:0]  sig_q;
  logic [SIG_W-1:0]  exp_q;
  logic [15:0]       cnt_q;
  logic [15:0]       nsamp_q;
  logic [IDLE_W-1:0] idle_q;
  logic              busy_q;
  logic              out_valid_q;
  logic              timeout_q;

  logic [NCH*SIG_W-1:0] y_pad;
  logic [SIG_W-1:0]     fold;
  logic [SIG_W-1:0]     sig_d;

  // Zero-pad y to whole chunks, then XOR the chunks so bit i lands on bit i mod SIG_W.
  always_comb begin
    y_pad          = '0;
    y_pad[Y_W-1:0] = bus.y;
    fold           = '0;
    for (int c = 0; c < NCH; c++) begin
      fold = fold ^ y_pad[c*SIG_W +: SIG_W];
    end
    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sig_q       <= SEED;
      exp_q       <= '0;
      cnt_q       <= '0;
      nsamp_q     <= '0;
      idle_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            nsamp_q   <= bus.num_samples;
            exp_q     <= bus.expected_sig;
            sig_q     <= SEED;
            cnt_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            if (bus.num_samples == 16'd0) begin
              state_q     <= REPORT;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
              busy_q  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.y_valid) begin
            sig_q  <= sig_d;
            idle_q <= '0;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (cnt_q == nsamp_q - 16'd1) begin
              state_q     <= REPORT;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end else begin
            idle_q <= idle_q + 1'b1;
            // The TIMEOUT-th consecutive idle cycle ends the run with the signature frozen.
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
              state_q     <= REPORT;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              timeout_q   <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.sig        = sig_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.timeout    = out_valid_q & timeout_q;
  assign bus.match      = out_valid_q & (sig_q == exp_q);
endmodule

// File: tb/tb_fuzz_sig_collector.sv
// Directed bench for fuzz_sig_collector: stimulus pushes expected results, a negedge monitor
// pops and compares each new report; inline checks cover reset, latency and stability.
module tb_fuzz_sig_collector;
  localparam int Y_W = 350;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct packed {
    logic [31:0] sig;
    logic [15:0] cnt;
    logic        match;
    logic        timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuzz_sig_collector_if #(.Y_W(Y_W), .SIG_W(32)) bus ();

  fuzz_sig_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   seen  = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Scoreboard monitor: compare once per report on the first cycle out_valid is seen.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: report sig=%0h with empty queue", bus.sig);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sig", 64'(bus.sig), 64'(e.sig));
        check("sb_cnt", 64'(bus.sample_cnt), 64'(e.cnt));
        check("sb_match", 64'(bus.match), 64'(e.match));
        check("sb_timeout", 64'(bus.timeout), 64'(e.timeout));
      end
    end else if (!bus.out_valid) begin
      seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [31:0] e);
    bus.start = 1'b1;
    bus.num_samples = n;
    bus.expected_sig = e;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [Y_W-1:0] v);
    bus.y = v;
    bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    bus.y = '0;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ack_out_valid_low", 64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [Y_W-1:0] bitv(input int i);
    logic [Y_W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 1'b0; bus.num_samples = '0; bus.y = '0; bus.y_valid = 1'b0;
    bus.expected_sig = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sig", 64'(bus.sig), 64'd0);
    check("rst_cnt", 64'(bus.sample_cnt), 64'd0);

    // y_valid in IDLE is ignored
    send(bitv(0));
    check("idle_ignore_sig", 64'(bus.sig), 64'd0);

    // Basic: y=1 twice -> 1, 3
    exp_q.push_back('{sig: 32'd3, cnt: 16'd2, match: 1'b1, timeout: 1'b0});
    do_start(16'd2, 32'd3);
    check("basic_busy", 64'(bus.busy), 64'd1);
    send(bitv(0));
    check("basic_sig1", 64'(bus.sig), 64'd1);
    check("basic_not_done", 64'(bus.out_valid), 64'd0);
    send(bitv(0));
    check("basic_latency", 64'(bus.out_valid), 64'd1);
    check("basic_busy_low", 64'(bus.busy), 64'd0);
    ack();

    // Fold: bits 0 and 32 cancel; bit 349 lands on bit 29
    exp_q.push_back('{sig: 32'd0, cnt: 16'd1, match: 1'b1, timeout: 1'b0});
    do_start(16'd1, 32'd0);
    send(bitv(0) | bitv(32));
    ack();
    exp_q.push_back('{sig: 32'h20000000, cnt: 16'd1, match: 1'b0, timeout: 1'b0});
    do_start(16'd1, 32'd0);
    send(bitv(349));
    ack();

    // Feedback: bit31 then 0 -> POLY
    exp_q.push_back('{sig: POLY, cnt: 16'd2, match: 1'b1, timeout: 1'b0});
    do_start(16'd2, POLY);
    send(bitv(31));
    check("fb_sig1", 64'(bus.sig), 64'h80000000);
    send('0);
    ack();

    // Timeout with a 63-cycle gap that must not fire; signature 1,3,7
    exp_q.push_back('{sig: 32'd7, cnt: 16'd3, match: 1'b0, timeout: 1'b1});
    do_start(16'd5, 32'd0);
    send(bitv(0));
    for (int i = 0; i < 63; i++) tick();
    check("gap63_no_timeout", 64'(bus.out_valid), 64'd0);
    send(bitv(0));
    for (int i = 0; i < 10; i++) tick();
    send(bitv(0));
    check("to_busy", 64'(bus.busy), 64'd1);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      tick();
      k++;
    end
    check("to_latency", 64'(k), 64'd64);

    // Stall in REPORT while toggling y_valid/start
    for (int i = 0; i < 10; i++) begin
      bus.y_valid = i[0];
      bus.start = ~i[0];
      bus.num_samples = 16'd9;
      bus.y = {11{32'(i * 32'h1234567 + 1)}};
      tick();
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_sig", 64'(bus.sig), 64'd7);
    end
    check("stall_cnt", 64'(bus.sample_cnt), 64'd3);
    check("stall_timeout", 64'(bus.timeout), 64'd1);
    bus.y_valid = 1'b0; bus.y = '0;
    // start coinciding with the accept is not honoured
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    check("accept_start_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("accept_start_busy", 64'(bus.busy), 64'd0);
    check("idle_hold_sig", 64'(bus.sig), 64'd7);
    check("idle_hold_cnt", 64'(bus.sample_cnt), 64'd3);

    // num_samples=0 -> immediate report with SEED
    exp_q.push_back('{sig: 32'd0, cnt: 16'd0, match: 1'b1, timeout: 1'b0});
    do_start(16'd0, 32'd0);
    check("zero_latency", 64'(bus.out_valid), 64'd1);
    ack();

    // start during COLLECT is ignored
    exp_q.push_back('{sig: 32'd3, cnt: 16'd2, match: 1'b1, timeout: 1'b0});
    do_start(16'd2, 32'd3);
    send(bitv(0));
    do_start(16'd9, 32'hFFFF);
    check("collect_start_cnt", 64'(bus.sample_cnt), 64'd1);
    send(bitv(0));
    check("collect_start_done", 64'(bus.out_valid), 64'd1);
    ack();

    // Reset mid-COLLECT with y_valid high
    do_start(16'd4, 32'd0);
    send(bitv(0));
    rst = 1'b1;
    bus.y = bitv(5);
    bus.y_valid = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus.y_valid = 1'b0;
    check("mrst_sig", 64'(bus.sig), 64'd0);
    check("mrst_cnt", 64'(bus.sample_cnt), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_match", 64'(bus.match), 64'd0);
    check("mrst_timeout", 64'(bus.timeout), 64'd0);
    bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    check("mrst_idle_sig", 64'(bus.sig), 64'd0);

    tick(); tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
